ysyx_imem_responder: RTL and testbench

Read-side responder for the simple fetch bus (`araddr`/`arvalid` → `rdata`/`rvalid`) driven by the instruction fetch unit. It accepts one read at a time, models a fixed access latency, and returns a word from an internal word-addressed instruction memory with an error flag for misaligned or out-of-range addresses. It sits between the IFU and the memory map in simulation and FPGA builds. A side-band load port lets the bench or boot logic fill the memory.

---
 rtl/ysyx_imem_responder_pkg.sv | 14 +
 rtl/ysyx_imem_responder_if.sv | 29 ++
 rtl/ysyx_imem_array.sv | 24 ++
 rtl/ysyx_imem_responder.sv | 104 ++++++++++
 tb/tb_ysyx_imem_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_imem_responder_pkg.sv
// Shared types for the instruction-memory read responder.
// FSM state encoding and counter sizing.
package ysyx_imem_responder_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2,
    RSP_DONE = 2'd3
  } rsp_state_e;

endpackage

// File: rtl/ysyx_imem_responder_if.sv
// Fetch-bus read channel plus side-band memory load port.
// master = IFU/bench side, slave = responder side.
interface ysyx_imem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rerr;
  logic              busy;
  logic              load_we;
  logic [IDX_W-1:0]  load_idx;
  logic [DATA_W-1:0] load_data;

  modport master (
    output araddr, arvalid,
    output load_we, load_idx, load_data,
    input  rdata, rvalid, rerr, busy
  );

  modport slave (
    input  araddr, arvalid,
    input  load_we, load_idx, load_data,
    output rdata, rvalid, rerr, busy
  );
endinterface

// File: rtl/ysyx_imem_array.sv
// DEPTH x DATA_W synchronous RAM, one read and one write port.
// No reset; a same-edge write is not seen by the read (old data).
module ysyx_imem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [DATA_W-1:0] o_rdata,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_ridx];
  end

endmodule

// File: rtl/ysyx_imem_responder.sv
// Fixed-latency read responder for the fetch bus.
// One request in flight; DONE swallows the held arvalid.
module ysyx_imem_responder
  import ysyx_imem_responder_pkg::*;
#(
  parameter int              ADDR_W  = 32,
  parameter int              DATA_W  = 32,
  parameter int              DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE  = 32'h8000_0000,
  parameter int              LATENCY = 2
) (
  input logic clk,
  input logic rst,
  ysyx_imem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1 =
    CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W-3:0] WLIM =
    (ADDR_W-2)'(DEPTH);

  rsp_state_e r_state;
  rsp_state_e w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;

  logic              w_re;
  logic              w_err;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_q;

  // LATENCY=1 reads on the accept edge, before r_addr is loaded
  assign w_addr = (r_state == RSP_IDLE) ?
                  bus.araddr : r_addr;
  assign w_off  = w_addr - BASE;
  assign w_idx  = w_off[IDX_W+1:2];
  assign w_err  = (w_addr[1:0] != 2'b00) ||
                  (w_off[ADDR_W-1:2] >= WLIM);

  always_comb begin
    w_next = r_state;
    w_re   = 1'b0;
    unique case (r_state)
      RSP_IDLE: begin
        if (bus.arvalid) begin
          w_next = (LATENCY == 1) ?
                   RSP_RESP : RSP_WAIT;
          w_re   = (LATENCY == 1);
        end
      end
      RSP_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = RSP_RESP;
          w_re   = 1'b1;
        end
      end
      RSP_RESP: w_next = RSP_DONE;
      RSP_DONE: w_next = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RSP_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == RSP_IDLE && bus.arvalid) begin
        r_addr <= bus.araddr;
        r_cnt  <= LAT_M1;
      end else if (r_state == RSP_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_re) r_err <= w_err;
    end
  end

  ysyx_imem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_re    (w_re),
    .i_ridx  (w_idx),
    .o_rdata (w_q),
    .i_we    (bus.load_we),
    .i_widx  (bus.load_idx),
    .i_wdata (bus.load_data)
  );

  assign bus.rvalid = (r_state == RSP_RESP);
  assign bus.busy   = (r_state != RSP_IDLE);
  assign bus.rerr   = bus.rvalid && r_err;
  assign bus.rdata  = (bus.rvalid && !r_err) ?
                      w_q : '0;

endmodule

// File: tb/tb_ysyx_imem_responder.sv
// Bench for ysyx_imem_responder: LATENCY=2 and LATENCY=1 instances
// share stimulus; a transaction-level model feeds per-DUT queues.
module tb_ysyx_imem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          NPRE  = 16;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] araddr    = '0;
  logic        arvalid   = 1'b0;
  logic        load_we   = 1'b0;
  logic [9:0]  load_idx  = '0;
  logic [31:0] load_data = '0;

  ysyx_imem_responder_if #(.ADDR_W(32), .DATA_W(32), .IDX_W(10)) bus_a ();
  ysyx_imem_responder_if #(.ADDR_W(32), .DATA_W(32), .IDX_W(10)) bus_b ();

  assign bus_a.araddr    = araddr;
  assign bus_a.arvalid   = arvalid;
  assign bus_a.load_we   = load_we;
  assign bus_a.load_idx  = load_idx;
  assign bus_a.load_data = load_data;
  assign bus_b.araddr    = araddr;
  assign bus_b.arvalid   = arvalid;
  assign bus_b.load_we   = load_we;
  assign bus_b.load_idx  = load_idx;
  assign bus_b.load_data = load_data;

  ysyx_imem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
    .BASE(BASE), .LATENCY(2)
  ) u_a (.clk(clk), .rst(rst_n), .bus(bus_a));

  ysyx_imem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
    .BASE(BASE), .LATENCY(1)
  ) u_b (.clk(clk), .rst(rst_n), .bus(bus_b));

  logic [1:0]  rv, by, er;
  logic [31:0] rd [2];
  assign rv    = {bus_b.rvalid, bus_a.rvalid};
  assign by    = {bus_b.busy,   bus_a.busy};
  assign er    = {bus_b.rerr,   bus_a.rerr};
  assign rd[0] = bus_a.rdata;
  assign rd[1] = bus_b.rdata;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  logic [31:0] mem [DEPTH];
  int          cyc = 0;
  int          acc [2];
  bit          pend [2];
  bit          has [2];
  int          free_at [2];
  logic [31:0] alat [2];
  exp_t        expq [2][$];
  int          checks = 0;
  int          failures = 0;
  int          pulses0 = 0;
  bit          fin = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic exp_t ref_read(input logic [31:0] a, input int due);
    exp_t        e;
    logic [31:0] off;
    off   = a - BASE;
    e.due = due;
    e.err = (a % 4 != 0) || (off >= 32'(4 * DEPTH));
    e.data = e.err ? 32'h0 : mem[int'(off / 4)];
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0;
      has[k] = 1'b0;
      free_at[k] = 0;
      expq[k].delete();
    end
  endtask

  initial model_reset();

  // Transaction model: accept, then read on edge acc+L-1, then loads
  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && arvalid && cyc >= free_at[k]) begin
          acc[k] = cyc;
          pend[k] = 1'b1;
          has[k] = 1'b1;
          free_at[k] = cyc + lat_of(k) + 2;
          alat[k] = araddr;
        end
        if (pend[k] && cyc == acc[k] + lat_of(k) - 1) begin
          expq[k].push_back(ref_read(alat[k], acc[k] + lat_of(k)));
          pend[k] = 1'b0;
        end
      end
    end
    if (load_we) mem[load_idx] = load_data;
    cyc++;
  end

  always @(negedge clk) begin
    if (!fin) begin
      for (int k = 0; k < 2; k++) begin
        logic eb;
        exp_t e;
        eb = has[k] && cyc > acc[k] && cyc <= acc[k] + lat_of(k) + 1;
        chk($sformatf("busy%0d", k), 32'(by[k]), 32'(eb));
        if (rv[k]) begin
          if (k == 0) pulses0++;
          checks++;
          if (expq[k].size() == 0) begin
            failures++;
            $display("FAIL unexpected_rvalid%0d: got rvalid=1 want 0 (cycle %0d)", k, cyc);
          end else begin
            e = expq[k].pop_front();
            chk($sformatf("resp_cycle%0d", k), cyc, e.due);
            chk($sformatf("rdata%0d", k), rd[k], e.data);
            chk($sformatf("rerr%0d", k), 32'(er[k]), 32'(e.err));
          end
        end else begin
          chk($sformatf("idle_out%0d", k), rd[k] | 32'(er[k]), 32'h0);
          if (expq[k].size() > 0 && expq[k][0].due <= cyc) begin
            e = expq[k].pop_front();
            checks++;
            failures++;
            $display("FAIL missing_rvalid%0d: got rvalid=0 want 1 (cycle %0d)", k, cyc);
          end
        end
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic v,
                       input logic we, input int idx,
                       input logic [31:0] d);
    araddr = a;
    arvalid = v;
    load_we = we;
    load_idx = 10'(idx);
    load_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'h0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic req(input logic [31:0] a);
    for (int i = 0; i < 3; i++) drive(a, 1'b1, 1'b0, 0, 32'h0);
    idle(3);
  endtask

  initial begin
    int          p;
    logic [31:0] errs [3];
    logic [31:0] a;
    int          mode;
    int          hold;

    errs[0] = 32'h8000_0012;
    errs[1] = BASE + 32'(4 * DEPTH);
    errs[2] = 32'h7FFF_FFFC;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NPRE; i++)
      drive(32'h0, 1'b0, 1'b1, i, $urandom);
    drive(32'h0, 1'b0, 1'b1, 4, 32'h0010_0093);

    p = pulses0;
    for (int i = 0; i < 6; i++)
      drive(32'h8000_0010, 1'b1, 1'b0, 0, 32'h0);
    idle(4);
    chk("held_pulses", 32'(pulses0 - p), 32'd2);

    for (int i = 0; i < 3; i++) req(errs[i]);

    drive(BASE + 32'd28, 1'b1, 1'b1, 7, 32'hCAFE_F00D);
    drive(BASE + 32'd28, 1'b1, 1'b0, 0, 32'h0);
    drive(BASE + 32'd28, 1'b1, 1'b0, 0, 32'h0);
    idle(3);
    req(BASE + 32'd28);

    araddr = 32'h8000_0010;
    arvalid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    arvalid = 1'b0;
    model_reset();
    #1;
    chk("rst_rvalid", 32'(rv), 32'h0);
    chk("rst_busy", 32'(by), 32'h0);
    chk("rst_rdata", rd[0] | rd[1], 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req(32'h8000_0010);

    for (int it = 0; it < 150; it++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0, 1: a = BASE + 32'(4 * $urandom_range(0, NPRE - 1));
        2: a = BASE + 32'(4 * $urandom_range(0, NPRE - 1))
                    + 32'($urandom_range(1, 3));
        default: a = ($urandom_range(0, 1) == 1) ?
                     BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 999)) :
                     BASE - 32'(4 * $urandom_range(1, 999));
      endcase
      hold = $urandom_range(1, 6);
      for (int i = 0; i < hold; i++)
        drive(a, 1'b1, 1'($urandom_range(0, 1)),
              $urandom_range(0, NPRE - 1), $urandom);
      for (int i = 0; i < $urandom_range(0, 3); i++)
        drive(32'h0, 1'b0, 1'($urandom_range(0, 1)),
              $urandom_range(0, NPRE - 1), $urandom);
    end

    idle(8);
    fin = 1'b1;
    chk("drain0", 32'(expq[0].size()), 32'h0);
    chk("drain1", 32'(expq[1].size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
